// File: rtl/sincos_arbiter.sv
// sincos_arbiter: round-robin sharing of one sin engine among NUM_CH channels,
// with tag tracking and credit-protected per-channel response FIFOs.
module sincos_arbiter #(
   parameter int NUM_CH       = 4,
   parameter int ENG_LAT      = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_i,
   input  logic [NUM_CH-1:0]              req_valid_i,
   output logic [NUM_CH-1:0]              req_ready_o,
   input  logic [NUM_CH*32-1:0]           req_phase_i,
   input  logic [NUM_CH-1:0]              req_cos_i,
   output logic [NUM_CH-1:0]              rsp_valid_o,
   input  logic [NUM_CH-1:0]              rsp_ready_i,
   output logic [NUM_CH*OUTPUT_WIDTH-1:0] rsp_data_o,
   output logic [31:0]                    eng_phase_o,
   output logic                           eng_valid_o,
   input  logic [OUTPUT_WIDTH-1:0]        eng_result_i,
   input  logic                           eng_valid_i,
   output logic                           busy_o,
   output logic                           err_o
);
   localparam int CW = $clog2(NUM_CH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int KW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = ENG_LAT * (CW + 1);

   logic [NUM_CH-1:0]  eligible, hit, push, pop, full, ovf;
   logic [31:0]        phase [NUM_CH];
   logic [CW-1:0]      last_grant, win, idx, eng_ch;
   logic               found, ret_ok;
   logic [TW-1:0]      tag;
   logic [ENG_LAT-1:0] tag_v;

   always_comb begin
      found = 1'b0;
      win = last_grant;
      idx = last_grant;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CW'((int'(last_grant) + k) % NUM_CH);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
      req_ready_o = (found && !rst_i) ? NUM_CH'(1) << win : '0;
   end

   // Tag stages are packed {valid, channel}; stage 0 sits in the low bits and
   // pairs with the cycle after eng_valid_o, so the top stage meets eng_valid_i.
   for (genvar s = 0; s < ENG_LAT; s++) begin : g_tag
      assign tag_v[s] = tag[s*(CW+1) + CW];
   end

   assign ret_ok = eng_valid_i && tag[TW-1];

   always_ff @(posedge clk) begin
      if (rst_i) begin
         eng_valid_o <= 1'b0;
         eng_phase_o <= '0;
         eng_ch      <= '0;
         last_grant  <= CW'(NUM_CH - 1);
         tag         <= '0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         eng_valid_o <= found;
         if (found) begin
            eng_phase_o <= phase[win] + (req_cos_i[win] ? 32'h4000_0000 : 32'h0);
            eng_ch      <= win;
            last_grant  <= win;
         end
         tag    <= TW'({tag, eng_valid_o, eng_ch});
         busy_o <= eng_valid_o || (|tag_v) || (|rsp_valid_o);
         err_o  <= err_o || (eng_valid_i != tag[TW-1]) || (|ovf);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW:0]             wr_ptr, rd_ptr;
      logic [KW-1:0]           credit;
      assign phase[c]       = req_phase_i[c*32 +: 32];
      assign eligible[c]    = req_valid_i[c] && credit != '0;
      assign full[c]        = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
      assign rsp_valid_o[c] = wr_ptr != rd_ptr;
      assign pop[c]         = rsp_valid_o[c] && rsp_ready_i[c];
      assign hit[c]         = ret_ok && tag[TW-2 -: CW] == CW'(c);
      assign push[c]        = hit[c] && !full[c];
      assign ovf[c]         = hit[c] && full[c];
      assign rsp_data_o[c*OUTPUT_WIDTH +: OUTPUT_WIDTH] = mem[rd_ptr[AW-1:0]];
      always_ff @(posedge clk) begin
         if (rst_i) begin
            credit <= KW'(FIFO_DEPTH);
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            credit <= credit + KW'(pop[c]) - KW'(req_ready_o[c]);
            if (push[c]) wr_ptr <= wr_ptr + 1'b1;
            if (pop[c]) rd_ptr <= rd_ptr + 1'b1;
         end
      end
      always_ff @(posedge clk) begin
         if (push[c]) mem[wr_ptr[AW-1:0]] <= eng_result_i;
      end
   end
endmodule
